// File: rtl/win_pkg.sv
// Shared definitions for the KxK sliding-window generator: coordinate width,
// frame-tracking states and the flat window element index.
package win_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Element (i,j) of a k-wide window lives at slot i*k+j of the flat output.
  function automatic int win_idx(input int i, input int j, input int k);
    return i * k + j;
  endfunction

endpackage

// File: rtl/wingen_line_buf.sv
// One image line of pixel storage: combinational read, write on accept.
// Read-before-write falls out naturally since the write lands at the clock edge.
module wingen_line_buf #(
  parameter int DEPTH      = 638,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_kxk.sv
// KxK sliding-window generator over a raster stream with frame tracking.
// Optional macro WINGEN_COORD_EN adds out_row/out_col top-left coordinates.
module window_gen_kxk
  import win_pkg::*;
#(
  parameter int IMG_W      = 638,
  parameter int IMG_H      = 510,
  parameter int KSIZE      = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                sof,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   out_win,
  output logic                                out_eof,
  output logic                                frame_err
`ifdef WINGEN_COORD_EN
  ,
  output logic [COORD_W-1:0]                  out_row,
  output logic [COORD_W-1:0]                  out_col
`endif
);

  localparam int AW = $clog2(IMG_W);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] KM1      = COORD_W'(KSIZE - 1);

  state_t state, state_nxt;
  logic [COORD_W-1:0] col, row, pc, pr;
  logic accept, take, err_set, is_last, win_ok;
  logic [KSIZE-2:0][DATA_WIDTH-1:0] lb_rd;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [KSIZE*KSIZE*DATA_WIDTH-1:0] win_flat;

  assign in_ready = out_ready || !out_valid;
  assign accept   = in_valid && in_ready;
  // sof forces the current pixel to (0,0) regardless of the counters.
  assign pc       = sof ? '0 : col;
  assign pr       = sof ? '0 : row;
  assign is_last  = (pr == LAST_ROW) && (pc == LAST_COL);
  assign win_ok   = take && (pr >= KM1) && (pc >= KM1);

  // Line buffer k holds the row k+1 lines above the incoming pixel.
  for (genvar k = 0; k < KSIZE-1; k++) begin : g_lb
    logic [DATA_WIDTH-1:0] wd;
    if (k == 0) begin : g_head
      assign wd = in_data;
    end else begin : g_chain
      assign wd = lb_rd[k-1];
    end
    wingen_line_buf #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH)) u_lb (
      .clk   (clk),
      .we    (take),
      .addr  (pc[AW-1:0]),
      .wdata (wd),
      .rdata (lb_rd[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (take) state_nxt = is_last ? DONE : RUN;
  end

  always_comb begin
    take    = accept && (sof || state == RUN);
    err_set = accept && !sof && (state == DONE);
  end

  // Shift columns left; the new right column is oldest line at top.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE-1; j++)
        win_d[i][j] = win_q[i][j+1];
    for (int i = 0; i < KSIZE-1; i++)
      win_d[i][KSIZE-1] = lb_rd[KSIZE-2-i];
    win_d[KSIZE-1][KSIZE-1] = in_data;
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        win_flat[win_idx(i, j, KSIZE)*DATA_WIDTH +: DATA_WIDTH] = win_d[i][j];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      win_q <= '0;
    end else if (take) begin
      win_q <= win_d;
      if (pc == LAST_COL) begin
        col <= '0;
        row <= is_last ? '0 : pr + 1'b1;
      end else begin
        col <= pc + 1'b1;
        row <= pr;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_win   <= '0;
    end else if (accept) begin
      out_valid <= win_ok;
      out_eof   <= win_ok && is_last;
      if (win_ok) out_win <= win_flat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                frame_err <= 1'b0;
    else if (accept && sof)    frame_err <= 1'b0;
    else if (err_set)          frame_err <= 1'b1;

`ifdef WINGEN_COORD_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_row <= '0;
      out_col <= '0;
    end else if (win_ok) begin
      out_row <= pr - KM1;
      out_col <= pc - KM1;
    end
`endif

endmodule
